mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while fetch waits (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  input  1  fetch read request, held until if_rvalid.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address, stable while if_req.
REQ-007 SHALL have port if_rvalid  output  1  one-cycle pulse: fetch data valid on rdata.
REQ-008 SHALL have port dm_req  input  1  data request, held until dm_rvalid.
REQ-009 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port dm_be  input  4  store byte enables.
REQ-011 SHALL have port dm_addr  input  ADDR_W  data address.
REQ-012 SHALL have port dm_wdata  input  32  store data.
REQ-013 SHALL have port dm_rvalid  output  1  one-cycle pulse: load data valid or store acknowledged.
REQ-014 SHALL have port rdata  output  32  shared read data, mem_rdata passed through.
REQ-015 SHALL have port mem_req  output  1  request to single memory port.
REQ-016 SHALL have ports mem_we/mem_be/mem_addr/mem_wdata  output  1/4/ADDR_W/32  muxed from owner; fetch forces we=0, be=4'hF.
REQ-017 SHALL have port mem_gnt  input  1  memory accepted request this cycle.
REQ-018 SHALL have port mem_rvalid  input  1  memory response (load data or store ack).
REQ-019 SHALL have port mem_rdata  input  32  memory read data.
REQ-020 SHALL have ports if_stall, dm_stall  output  1 each  stall to pipeline: if_req&~if_rvalid, dm_req&~dm_rvalid.

Function
REQ-021 SHALL implement FSM IDLE, WAIT_GNT, WAIT_RSP plus owner register (IF/DM); one outstanding transaction.
REQ-022 IDLE: if any request, SHALL latch owner and go WAIT_GNT next cycle; else stay.
REQ-023 Arbitration SHALL give DM priority over IF when both request in IDLE (older instruction wins).
REQ-024 WAIT_GNT: mem_req=1 with owner fields stable; on mem_gnt SHALL go WAIT_RSP.
REQ-025 WAIT_RSP: mem_req=0; on mem_rvalid SHALL pulse owner's rvalid same cycle and go IDLE.
REQ-026 Non-owner rvalid SHALL stay 0; mem_rvalid in IDLE/WAIT_GNT SHALL be ignored.
REQ-027 Minimum latency: req in cycle 0, mem_gnt in cycle 1, mem_rvalid in cycle 2 -> rvalid in cycle 2; no back-to-back, next arbitration in the cycle after rvalid.
REQ-028 Simultaneous new requests and mem_rvalid SHALL be arbitrated in the following IDLE cycle.
REQ-029 Requester dropping req before rvalid is a protocol violation; transaction SHALL still complete and pulse rvalid.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, owner=IF, mem_req=0, if_rvalid=dm_rvalid=0, starvation counter=0, independent of clk.
REQ-031 Reset mid-transaction SHALL abandon it; late mem_rvalid after reset SHALL be ignored.

Configuration
REQ-032 With ARB_STARVE_GUARD_EN defined: 4-bit counter SHALL count DM grants issued while if_req=1; at STARVE_LIMIT, next IDLE arbitration SHALL pick IF; counter SHALL clear on IF grant or if_req=0.
REQ-033 Without ARB_STARVE_GUARD_EN: counter SHALL be absent; fixed DM priority.

Structure
REQ-034 State and owner encodings SHALL live in shared package riscv_pkg; single module, no sub-module.

Verification
REQ-035 Lone load dm_addr=0x100, mem_gnt cycle 1, mem_rvalid cycle 2 with mem_rdata=0xDEADBEEF -> dm_rvalid cycle 2, rdata=0xDEADBEEF, if_rvalid=0.
REQ-036 if_req and dm_req both in cycle 0 -> DM served first, IF mem_req asserts cycle after dm_rvalid; if_stall high throughout.
REQ-037 Store dm_be=4'b0011, mem_gnt held low 3 cycles -> mem_req and fields stable, mem_we=1, mem_be=0011 until gnt.
REQ-038 Guard enabled, STARVE_LIMIT=2, dm_req continuous, if_req continuous -> grant order DM,DM,IF,DM,DM,IF.
REQ-039 rst_n low in WAIT_RSP, then mem_rvalid pulse -> mem_req=0 immediately, no rvalid pulse, FSM IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the single-port memory arbiter: FSM states, port owner,
// starvation counter width and the all-bytes enable used for instruction fetches.
// No logic lives here.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RSP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  localparam int         STARVE_CNT_W = 4;
  localparam logic [3:0] BE_ALL       = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (IF) and data (DM), one transaction in flight.
// Latency: req cycle 0 -> mem_req cycle 1 -> earliest rvalid cycle 2; re-arbitration in the cycle after rvalid.
// Backpressure: mem_req holds with stable fields until mem_gnt; requesters stall (if_stall/dm_stall) until rvalid.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_req/if_addr -> if_rvalid        fetch read channel
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata -> dm_rvalid   data load/store channel
//   rdata                              shared read data (mem_rdata passthrough)
//   mem_req/we/be/addr/wdata, mem_gnt, mem_rvalid, mem_rdata   single memory port
//   if_stall, dm_stall                 pipeline stalls
// Build option: define ARB_STARVE_GUARD_EN to stop DM from starving IF beyond STARVE_LIMIT grants.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_rvalid,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              if_stall,
  output logic              dm_stall
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic       any_req;
  logic       pick_dm;

  assign any_req = if_req | dm_req;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Once fetch has watched LIMIT data grants go by, it takes the next slot.
  assign pick_dm = dm_req & ~(if_req & (starve_cnt_q >= LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req) begin
      starve_cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (pick_dm) begin
        // Saturate rather than wrap so a long run never hands DM extra grants.
        if (starve_cnt_q != '1) starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  // Fixed priority: the older (data) instruction always wins.
  assign pick_dm = dm_req;

  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    mem_req   = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = pick_dm ? OWN_DM : OWN_IF;
          state_d = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        // Response is forwarded combinationally so rvalid lands in the same cycle.
        if (mem_rvalid) begin
          if (owner_q == OWN_DM) dm_rvalid = 1'b1;
          else                   if_rvalid = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Fields follow the latched owner; fetches are always full-word reads.
  assign mem_we    = (owner_q == OWN_DM) ? dm_we    : 1'b0;
  assign mem_be    = (owner_q == OWN_DM) ? dm_be    : BE_ALL;
  assign mem_addr  = (owner_q == OWN_DM) ? dm_addr  : if_addr;
  assign mem_wdata = (owner_q == OWN_DM) ? dm_wdata : 32'h0;

  assign rdata    = mem_rdata;
  assign if_stall = if_req & ~if_rvalid;
  assign dm_stall = dm_req & ~dm_rvalid;

endmodule
